// File: rtl/kgp_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the KGP-RISC datapath.
// Define STALL_TIMEOUT_EN to enable the MEM stall timeout and the ERR state.
module kgp_multicycle_sequencer #(
    parameter logic [5:0] HALT_OPCODE = 6'b111111,
`ifdef STALL_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 16,
`endif
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic [5:0]       opcode,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             alu_en,
    output logic             mem_en,
    output logic             rf_we,
    output logic             pc_we,
    output logic             busy,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

`ifdef STALL_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            instr_cnt_q <= '0;
`ifdef STALL_TIMEOUT_EN
            tcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
`ifdef STALL_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_cnt_d = instr_cnt_q;
        ir_we       = 1'b0;
        alu_en      = 1'b0;
        mem_en      = 1'b0;
        rf_we       = 1'b0;
        pc_we       = 1'b0;
`ifdef STALL_TIMEOUT_EN
        tcnt_d      = tcnt_q;
`endif
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                ir_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
            S_EXEC: begin
                alu_en = 1'b1;
                if (mem_read || mem_write) begin
                    state_d = S_MEM;
`ifdef STALL_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end else if (reg_write) begin
                    state_d = S_WB;
                end else begin
                    pc_we = 1'b1;
                end
            end
            S_MEM: begin
                // A load (including read+write together) always finishes through WB.
                mem_en = 1'b1;
                if (mem_ready) begin
                    if (mem_read) state_d = S_WB;
                    else          pc_we   = 1'b1;
                end
`ifdef STALL_TIMEOUT_EN
                else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERR;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
`endif
            end
            S_WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
            end
            S_HALT:   if (start) state_d = S_FETCH;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_IDLE;
        endcase

        // Every retire is an instruction boundary.
        if (pc_we) begin
            state_d     = halt_req ? S_IDLE : S_FETCH;
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
    end

    assign busy      = !(state_q inside {S_IDLE, S_HALT, S_ERR});
`ifdef STALL_TIMEOUT_EN
    assign err       = (state_q == S_ERR);
`else
    assign err       = 1'b0;
`endif
    assign state     = state_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_kgp_multicycle_sequencer.sv
// Self-checking bench for kgp_multicycle_sequencer: vector table, corner sequences, random instructions.
module tb_kgp_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_we, alu_en, mem_en, rf_we, pc_we, busy, err;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    kgp_multicycle_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .opcode(opcode),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_ready(mem_ready), .ir_we(ir_we), .alu_en(alu_en), .mem_en(mem_en),
        .rf_we(rf_we), .pc_we(pc_we), .busy(busy), .err(err), .state(state),
        .instr_cnt(instr_cnt)
    );

    typedef struct {
        logic        start;
        logic        hreq;
        logic [5:0]  op;
        logic        mr, mw, rw, rdy;
        logic [2:0]  st;
        logic [5:0]  outs;   // {ir_we, alu_en, mem_en, rf_we, pc_we, busy}
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic h, input logic [5:0] op,
                                input logic mr, input logic mw, input logic rw,
                                input logic rdy, input logic [2:0] st,
                                input logic [5:0] o, input logic [31:0] c);
        vec_t v;
        v.start = s; v.hreq = h; v.op = op; v.mr = mr; v.mw = mw; v.rw = rw;
        v.rdy = rdy; v.st = st; v.outs = o; v.cnt = c;
        return v;
    endfunction

    function automatic logic [5:0] outs_now();
        return {ir_we, alu_en, mem_en, rf_we, pc_we, busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cls(input logic mr, input logic mw, input logic rw);
        mem_read = mr; mem_write = mw; reg_write = rw;
    endtask

    task automatic pulse_rst();
        start = 0; halt_req = 0; mem_ready = 0; set_cls(0, 0, 0);
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    initial begin
        int   cls, w, len, exp_rf, exp_me;
        int   pc_n, pc_idx, rf_n, me_n, ir_n;
        logic hq, lmr, lmw, lrw, at_idle;
        int   exp_cnt;

        // Reset held for three cycles: everything quiet.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_hold_outs", {29'd0, state}, 32'd0);
            chk("rst_hold_en", {25'd0, outs_now(), err}, 32'd0);
            chk("rst_hold_cnt", instr_cnt, 32'd0);
            next_cycle();
        end
        rst = 1'b1;

        // Cycle-by-cycle table: ALU op, stalled load, store, HALT, restart, branch with halt_req.
        tbl.push_back(mk(0,0,6'h00,0,0,0,0, 3'd0, 6'b000000, 0));
        tbl.push_back(mk(1,0,6'h00,0,0,0,0, 3'd0, 6'b000000, 0));
        tbl.push_back(mk(0,0,6'h00,0,0,1,0, 3'd1, 6'b100001, 0));
        tbl.push_back(mk(0,0,6'h00,0,0,1,0, 3'd2, 6'b000001, 0));
        tbl.push_back(mk(0,0,6'h00,0,0,1,0, 3'd3, 6'b010001, 0));
        tbl.push_back(mk(0,0,6'h00,0,0,1,0, 3'd5, 6'b000111, 0));
        tbl.push_back(mk(0,0,6'h23,1,0,1,0, 3'd1, 6'b100001, 1));
        tbl.push_back(mk(0,0,6'h23,1,0,1,0, 3'd2, 6'b000001, 1));
        tbl.push_back(mk(0,0,6'h23,1,0,1,0, 3'd3, 6'b010001, 1));
        tbl.push_back(mk(0,0,6'h23,1,0,1,0, 3'd4, 6'b001001, 1));
        tbl.push_back(mk(0,0,6'h23,1,0,1,0, 3'd4, 6'b001001, 1));
        tbl.push_back(mk(0,0,6'h23,1,0,1,0, 3'd4, 6'b001001, 1));
        tbl.push_back(mk(0,0,6'h23,1,0,1,1, 3'd4, 6'b001001, 1));
        tbl.push_back(mk(0,0,6'h23,1,0,1,0, 3'd5, 6'b000111, 1));
        tbl.push_back(mk(0,0,6'h2b,0,1,0,0, 3'd1, 6'b100001, 2));
        tbl.push_back(mk(0,0,6'h2b,0,1,0,0, 3'd2, 6'b000001, 2));
        tbl.push_back(mk(0,0,6'h2b,0,1,0,0, 3'd3, 6'b010001, 2));
        tbl.push_back(mk(0,0,6'h2b,0,1,0,1, 3'd4, 6'b001011, 2));
        tbl.push_back(mk(0,0,6'h3f,0,0,0,0, 3'd1, 6'b100001, 3));
        tbl.push_back(mk(0,0,6'h3f,0,0,0,0, 3'd2, 6'b000001, 3));
        tbl.push_back(mk(0,0,6'h3f,0,0,0,0, 3'd6, 6'b000000, 3));
        tbl.push_back(mk(0,1,6'h3f,0,0,0,0, 3'd6, 6'b000000, 3));
        tbl.push_back(mk(1,0,6'h3f,0,0,0,0, 3'd6, 6'b000000, 3));
        tbl.push_back(mk(0,1,6'h04,0,0,0,0, 3'd1, 6'b100001, 3));
        tbl.push_back(mk(0,1,6'h04,0,0,0,0, 3'd2, 6'b000001, 3));
        tbl.push_back(mk(0,1,6'h04,0,0,0,0, 3'd3, 6'b010011, 3));
        tbl.push_back(mk(0,0,6'h04,0,0,0,0, 3'd0, 6'b000000, 4));

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start; halt_req = tbl[i].hreq; opcode = tbl[i].op;
            set_cls(tbl[i].mr, tbl[i].mw, tbl[i].rw); mem_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, tbl[i].st});
            chk($sformatf("vec%0d_outs", i), {25'd0, outs_now(), err}, {25'd0, tbl[i].outs, 1'b0});
            chk($sformatf("vec%0d_cnt", i), instr_cnt, tbl[i].cnt);
            next_cycle();
        end
        start = 0; halt_req = 0;

        // Asynchronous reset in the middle of a load's MEM wait.
        opcode = 6'h23;
        start = 1; next_cycle(); start = 0;
        set_cls(1, 0, 1); mem_ready = 0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rstmem_pre_state", {29'd0, state}, 32'd4);
        rst = 1'b0;
        #1;
        chk("rstmem_state", {29'd0, state}, 32'd0);
        chk("rstmem_outs", {26'd0, outs_now()}, 32'd0);
        chk("rstmem_cnt", instr_cnt, 32'd0);
        next_cycle();
        rst = 1'b1; mem_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstmem_quiet", {27'd0, state, rf_we, pc_we}, 32'd0);
            next_cycle();
        end
        mem_ready = 0;

        // Load that never sees mem_ready.
        start = 1; next_cycle(); start = 0;
        set_cls(1, 0, 1);
        repeat (3) next_cycle();
`ifdef STALL_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("stall_mem_state", {29'd0, state}, 32'd4);
            next_cycle();
        end
        start = 1; halt_req = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("err_hold", {21'd0, state, err, busy, outs_now()}, {21'd0, 3'd7, 1'b1, 1'b0, 6'd0});
            next_cycle();
        end
        pulse_rst();
        // mem_ready arriving on the cycle the count hits the limit completes normally.
        start = 1; next_cycle(); start = 0;
        set_cls(1, 0, 1);
        repeat (3) next_cycle();
        for (int k = 0; k < 16; k++) begin
            mem_ready = (k == 15);
            next_cycle();
        end
        mem_ready = 0;
        @(negedge clk);
        chk("ready_wins", {28'd0, state, err}, {28'd0, 3'd5, 1'b0});
        next_cycle();
`else
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("stall_wait", {27'd0, state, err, mem_en}, {27'd0, 3'd4, 1'b0, 1'b1});
            next_cycle();
        end
`endif
        pulse_rst();

        // Random instruction stream against a transaction-level latency model.
        exp_cnt = 0;
        at_idle = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cls = $urandom_range(0, 4);
            w   = $urandom_range(0, 3);
            hq  = ($urandom_range(0, 7) == 0);
            case (cls)
                0:       {lmr, lmw, lrw} = 3'b000;
                1:       {lmr, lmw, lrw} = 3'b001;
                2:       {lmr, lmw, lrw} = {2'b10, 1'($urandom)};
                3:       {lmr, lmw, lrw} = {2'b01, 1'($urandom)};
                default: {lmr, lmw, lrw} = {2'b11, 1'($urandom)};
            endcase
            if (!(lmr || lmw)) len = lrw ? 4 : 3;
            else               len = lmr ? 5 + w : 4 + w;
            exp_rf = ((!(lmr || lmw) && lrw) || lmr) ? 1 : 0;
            exp_me = (lmr || lmw) ? w + 1 : 0;

            if (at_idle) begin
                start = 1; next_cycle(); start = 0;
            end
            opcode = 6'($urandom_range(0, 62));
            set_cls(lmr, lmw, lrw);
            halt_req = hq;
            pc_n = 0; pc_idx = -1; rf_n = 0; me_n = 0; ir_n = 0;
            for (int c = 0; c < len; c++) begin
                mem_ready = (c < 3) ? 1'($urandom) : (c == 3 + w);
                @(negedge clk);
                if (pc_we) begin pc_n++; pc_idx = c; end
                if (rf_we)  rf_n++;
                if (mem_en) me_n++;
                if (ir_we)  ir_n++;
                next_cycle();
            end
            exp_cnt++;
            chk($sformatf("rnd%0d_retire", i), {pc_n[15:0], pc_idx[15:0]}, {16'd1, 16'(len - 1)});
            chk($sformatf("rnd%0d_rf_we", i), rf_n, exp_rf);
            chk($sformatf("rnd%0d_mem_en", i), me_n, exp_me);
            chk($sformatf("rnd%0d_ir_we", i), ir_n, 1);
            chk($sformatf("rnd%0d_cnt", i), instr_cnt, exp_cnt);
            chk($sformatf("rnd%0d_next", i), {29'd0, state}, hq ? 32'd0 : 32'd1);
            at_idle = hq;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
